spi_master: RTL and testbench

Mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI master. It generates `sck`, `ss` and `mosi` from the system clock and captures `miso` into a receive byte. It is the initiator counterpart to the team's SPI slave, which samples on `sck` rising, shifts on `sck` falling and reloads its byte while `ss` is high. Host logic drives it through a `start`/`busy`/`done` handshake, with optional back-to-back bytes under one `ss` assertion.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_master_if.sv | 14 +
 rtl/spi_clk_gen.sv | 33 +++
 rtl/spi_master.sv | 132 +++++++++++++
 tb/tb_spi_master.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, bus mode and the master FSM state encoding.
package spi_pkg;
    localparam int SPI_WIDTH = 8;
    localparam bit CPOL      = 1'b0;
    localparam bit CPHA      = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        CONT,
        HOLD,
        GAP
    } spi_state_e;
endpackage

// File: rtl/spi_master_if.sv
// Host-side byte handshake of the SPI master: request/continue/data in, busy/done/data out.
interface spi_master_if;
    import spi_pkg::*;

    logic                 start;
    logic                 cont;
    logic [SPI_WIDTH-1:0] din;
    logic                 busy;
    logic                 done;
    logic [SPI_WIDTH-1:0] dout;

    modport master (output start, cont, din, input busy, done, dout);
    modport slave  (input start, cont, din, output busy, done, dout);
endinterface

// File: rtl/spi_clk_gen.sv
// Serial clock generator: CLK_DIV-cycle half periods while enabled, idle level otherwise.
module spi_clk_gen import spi_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       tick;

    assign tick = en && (cnt == 8'd0);
    // Strobes are combinational so the FSM acts on the same edge that moves sck.
    assign rise = tick && (sck == CPOL);
    assign fall = tick && (sck != CPOL);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= RELOAD;
            sck <= CPOL;
        end else if (cnt == 8'd0) begin
            cnt <= RELOAD;
            sck <= ~sck;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end
endmodule

// File: rtl/spi_master.sv
// Mode-0 MSB-first SPI master: byte FSM with shift registers, optional back-to-back bytes under one ss.
module spi_master import spi_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    spi_master_if.slave host,
    output logic        sck,
    output logic        ss,
    output logic        mosi,
    input  logic        miso
);
    localparam logic [7:0] TMR_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [2:0] LAST_BIT   = 3'(SPI_WIDTH - 1);

    spi_state_e           state;
    logic [SPI_WIDTH-2:0] tx;
    logic [SPI_WIDTH-1:0] rx;
    logic [2:0]           bit_cnt;
    logic                 cont_l;
    logic [7:0]           tmr;
    logic                 busy_r;
    logic                 done_r;
    logic [SPI_WIDTH-1:0] dout_r;
    logic                 clk_en;
    logic                 rise;
    logic                 fall;

    assign clk_en    = (state == SETUP) || (state == XFER);
    assign host.busy = busy_r;
    assign host.done = done_r;
    assign host.dout = dout_r;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (clk_en),
        .sck  (sck),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        done_r <= 1'b0;
        if (rst) begin
            state   <= IDLE;
            ss      <= 1'b1;
            mosi    <= 1'b0;
            busy_r  <= 1'b0;
            dout_r  <= '0;
            bit_cnt <= 3'd0;
            cont_l  <= 1'b0;
            tmr     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.start) begin
                        state   <= SETUP;
                        ss      <= 1'b0;
                        busy_r  <= 1'b1;
                        tx      <= host.din[SPI_WIDTH-2:0];
                        mosi    <= host.din[SPI_WIDTH-1];
                        cont_l  <= host.cont;
                        bit_cnt <= 3'd0;
                    end
                end
                SETUP: begin
                    if (rise) begin
                        rx    <= {rx[SPI_WIDTH-2:0], miso};
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (rise) begin
                        rx <= {rx[SPI_WIDTH-2:0], miso};
                    end else if (fall) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            // mosi keeps the last bit; the slave has already sampled it.
                            done_r <= 1'b1;
                            dout_r <= rx;
                            if (cont_l) begin
                                state <= CONT;
                            end else begin
                                state <= HOLD;
                                tmr   <= TMR_RELOAD;
                            end
                        end else begin
                            mosi <= tx[SPI_WIDTH-2];
                            tx   <= {tx[SPI_WIDTH-3:0], 1'b0};
                        end
                    end
                end
                CONT: begin
                    // busy stays high through the done cycle, so a request is taken from the next one.
                    if (busy_r) begin
                        busy_r <= 1'b0;
                    end else if (host.start) begin
                        state  <= XFER;
                        busy_r <= 1'b1;
                        tx     <= host.din[SPI_WIDTH-2:0];
                        mosi   <= host.din[SPI_WIDTH-1];
                        cont_l <= host.cont;
                    end else if (!host.cont) begin
                        state  <= HOLD;
                        busy_r <= 1'b1;
                        tmr    <= TMR_RELOAD;
                    end
                end
                HOLD: begin
                    if (tmr == 8'd0) begin
                        state <= GAP;
                        ss    <= 1'b1;
                        tmr   <= TMR_RELOAD;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                GAP: begin
                    if (tmr == 8'd0) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        mosi   <= 1'b0;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback timing table plus slave, burst, ignored-start and reset sequences.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_if h4 ();
    spi_master_if h7 ();

    logic sck4, ss4, mosi4, miso4;
    logic sck7, ss7, mosi7, miso7;
    logic use_slave = 1'b0;
    logic slave_miso;

    assign miso4 = use_slave ? slave_miso : mosi4;
    assign miso7 = mosi7;

    spi_master #(.CLK_DIV(4)) dut4 (
        .clk (clk), .rst (rst), .host (h4),
        .sck (sck4), .ss (ss4), .mosi (mosi4), .miso (miso4)
    );

    spi_master #(.CLK_DIV(7)) dut7 (
        .clk (clk), .rst (rst), .host (h7),
        .sck (sck7), .ss (ss7), .mosi (mosi7), .miso (miso7)
    );

    // Behavioural SPI slave on the CLK_DIV=4 master: samples on sck rise, shifts on fall.
    logic [7:0] s_din = 8'h00;
    logic [7:0] s_tx  = 8'h00;
    logic [7:0] s_rx  = 8'h00;
    logic [2:0] s_bits = 3'd0;
    logic       s_psck = 1'b0;
    logic       s_dly  = 1'b0;
    logic [7:0] s_q[$];

    always @(posedge clk) begin
        s_psck <= sck4;
        s_dly  <= s_tx[7];
        if (ss4) begin
            s_tx   <= s_din;
            s_bits <= 3'd0;
        end else if (sck4 && !s_psck) begin
            s_rx <= {s_rx[6:0], mosi4};
        end else if (!sck4 && s_psck) begin
            s_tx   <= {s_tx[6:0], 1'b0};
            s_bits <= s_bits + 3'd1;
            if (s_bits == 3'd7) s_q.push_back(s_rx);
        end
    end
    assign slave_miso = s_dly;

    logic burst_mon = 1'b0;
    int   ss_breaks = 0;
    always @(negedge clk) if (burst_mon && ss4) ss_breaks <= ss_breaks + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic start_req(input bit sel, input logic [7:0] d, input logic c);
        @(negedge clk);
        if (sel) begin h7.start = 1'b1; h7.din = d; h7.cont = c; end
        else     begin h4.start = 1'b1; h4.din = d; h4.cont = c; end
        @(posedge clk);
        #1;
        h7.start = 1'b0;
        h4.start = 1'b0;
    endtask

    // Results of the last monitor() call, in cycles after the accepting edge (-1 = not seen).
    int m_acc, m_rise, m_done, m_ss, m_busy, m_ndone, m_early, m_dout;
    int hi_min, hi_max, lo_min, lo_max;

    task automatic monitor(input bit sel, input int limit);
        logic c_sck, c_ss, c_busy, c_done;
        logic [7:0] c_dout;
        logic p_sck;
        int run;
        bit seen_rise;
        m_acc = 0; m_rise = -1; m_done = -1; m_ss = -1; m_busy = -1;
        m_ndone = 0; m_early = 0; m_dout = -1;
        hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
        p_sck = 1'b0; run = 0; seen_rise = 1'b0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            c_sck  = sel ? sck7 : sck4;
            c_ss   = sel ? ss7 : ss4;
            c_busy = sel ? h7.busy : h4.busy;
            c_done = sel ? h7.done : h4.done;
            c_dout = sel ? h7.dout : h4.dout;
            if (n == 1) m_acc = (!c_ss && c_busy) ? 1 : 0;
            if (c_sck != p_sck) begin
                if (c_sck) begin
                    if (!seen_rise) begin
                        m_rise = n;
                        seen_rise = 1'b1;
                    end else begin
                        if (run < lo_min) lo_min = run;
                        if (run > lo_max) lo_max = run;
                    end
                end else begin
                    if (run < hi_min) hi_min = run;
                    if (run > hi_max) hi_max = run;
                end
                run = 1;
            end else begin
                run++;
            end
            p_sck = c_sck;
            if (c_done) begin
                m_ndone++;
                if (m_done < 0) begin m_done = n; m_dout = int'(c_dout); end
            end
            if (m_done < 0 && c_ss) m_early++;
            if (m_done >= 0 && m_ss < 0 && c_ss) m_ss = n;
            if (m_done >= 0 && !c_busy) begin
                m_busy = n;
                break;
            end
        end
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] din;
        logic [7:0] exp_dout;
        int         exp_rise;
        int         exp_done;
        int         exp_ss;
        int         exp_busy;
        int         exp_half;
    } vec_t;

    vec_t vecs[6];

    initial begin
        h4.start = 1'b0; h4.cont = 1'b0; h4.din = 8'h00;
        h7.start = 1'b0; h7.cont = 1'b0; h7.din = 8'h00;

        // CLK_DIV=4: rise T+5, done T+65, ss T+69, busy T+73. CLK_DIV=7: T+8, T+113, T+120, T+127.
        vecs[0] = '{1'b0, 8'hA5, 8'hA5, 5, 65, 69, 73, 4};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 5, 65, 69, 73, 4};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 5, 65, 69, 73, 4};
        vecs[3] = '{1'b0, 8'h3C, 8'h3C, 5, 65, 69, 73, 4};
        vecs[4] = '{1'b0, 8'h81, 8'h81, 5, 65, 69, 73, 4};
        vecs[5] = '{1'b1, 8'h69, 8'h69, 8, 113, 120, 127, 7};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sck4", int'(sck4), 0);
        check("rst_ss4", int'(ss4), 1);
        check("rst_mosi4", int'(mosi4), 0);
        check("rst_busy4", int'(h4.busy), 0);
        check("rst_done4", int'(h4.done), 0);
        check("rst_dout4", int'(h4.dout), 0);
        check("rst_sck7", int'(sck7), 0);
        check("rst_ss7", int'(ss7), 1);
        check("rst_busy7", int'(h7.busy), 0);
        check("rst_dout7", int'(h7.dout), 0);
        rst = 1'b0;

        // Loopback table
        for (int i = 0; i < 6; i++) begin
            start_req(vecs[i].sel, vecs[i].din, 1'b0);
            monitor(vecs[i].sel, 3000);
            check($sformatf("v%0d_accept", i), m_acc, 1);
            check($sformatf("v%0d_rise", i), m_rise, vecs[i].exp_rise);
            check($sformatf("v%0d_done", i), m_done, vecs[i].exp_done);
            check($sformatf("v%0d_dout", i), m_dout, int'(vecs[i].exp_dout));
            check($sformatf("v%0d_ss_high", i), m_ss, vecs[i].exp_ss);
            check($sformatf("v%0d_busy_low", i), m_busy, vecs[i].exp_busy);
            check($sformatf("v%0d_ndone", i), m_ndone, 1);
            check($sformatf("v%0d_ss_early", i), m_early, 0);
            check($sformatf("v%0d_hi_min", i), hi_min, vecs[i].exp_half);
            check($sformatf("v%0d_hi_max", i), hi_max, vecs[i].exp_half);
            check($sformatf("v%0d_lo_min", i), lo_min, vecs[i].exp_half);
            check($sformatf("v%0d_lo_max", i), lo_max, vecs[i].exp_half);
        end

        // Against the slave model
        use_slave = 1'b1;
        s_din = 8'h3C;
        s_q.delete();
        start_req(1'b0, 8'hC3, 1'b0);
        monitor(1'b0, 3000);
        check("slv_mdout", m_dout, 8'h3C);
        check("slv_done", m_done, 65);
        check("slv_nrecv", s_q.size(), 1);
        check("slv_sdout", (s_q.size() > 0) ? int'(s_q[0]) : -1, 8'hC3);

        // Burst of three bytes under one ss
        s_q.delete();
        start_req(1'b0, 8'h01, 1'b1);
        monitor(1'b0, 3000);
        check("b0_done", m_done, 65);
        check("b0_busy_low", m_busy, 66);
        check("b0_ss", m_ss, -1);
        check("b0_early", m_early, 0);
        check("b0_mdout", m_dout, 8'h3C);
        burst_mon = 1'b1;
        start_req(1'b0, 8'h80, 1'b1);
        monitor(1'b0, 3000);
        check("b1_rise", m_rise, 5);
        check("b1_done", m_done, 65);
        check("b1_busy_low", m_busy, 66);
        check("b1_early", m_early, 0);
        start_req(1'b0, 8'hFF, 1'b0);
        burst_mon = 1'b0;
        monitor(1'b0, 3000);
        check("b2_rise", m_rise, 5);
        check("b2_done", m_done, 65);
        check("b2_ss_high", m_ss, 69);
        check("b2_early", m_early, 0);
        check("b_ss_breaks", ss_breaks, 0);
        check("b_nrecv", s_q.size(), 3);
        check("b_recv0", (s_q.size() > 0) ? int'(s_q[0]) : -1, 8'h01);
        check("b_recv1", (s_q.size() > 1) ? int'(s_q[1]) : -1, 8'h80);
        check("b_recv2", (s_q.size() > 2) ? int'(s_q[2]) : -1, 8'hFF);
        use_slave = 1'b0;

        // Explicit release from CONT: cont low with start low
        start_req(1'b0, 8'h96, 1'b1);
        monitor(1'b0, 3000);
        check("rel_dout", m_dout, 8'h96);
        check("rel_busy_low", m_busy, 66);
        h4.cont = 1'b0;
        begin
            int k_ss = -1;
            int k_busy = -1;
            for (int k = 1; k <= 100 && k_busy < 0; k++) begin
                @(negedge clk);
                if (k_ss < 0 && ss4) k_ss = k;
                if (!h4.busy) k_busy = k;
            end
            check("rel_ss_high", k_ss, 5);
            check("rel_busy_low2", k_busy, 9);
        end

        // start pulsed mid-transfer is dropped
        start_req(1'b0, 8'hA5, 1'b0);
        fork
            monitor(1'b0, 3000);
            begin
                repeat (10) @(negedge clk);
                h4.start = 1'b1;
                h4.din = 8'hFF;
                @(negedge clk);
                h4.start = 1'b0;
            end
        join
        check("ign_ndone", m_ndone, 1);
        check("ign_dout", m_dout, 8'hA5);
        check("ign_done", m_done, 65);
        check("ign_busy_low", m_busy, 73);
        begin
            int late_busy = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (h4.busy || !ss4) late_busy++;
            end
            check("ign_no_requeue", late_busy, 0);
        end

        // Reset during the 4th sck high phase
        start_req(1'b0, 8'hC3, 1'b0);
        begin
            int rises = 0;
            logic p = 1'b0;
            bit hit = 1'b0;
            for (int n = 0; n < 400 && !hit; n++) begin
                @(negedge clk);
                if (sck4 && !p) rises++;
                p = sck4;
                if (rises == 4) hit = 1'b1;
            end
            check("mid_rst_reached", int'(hit), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sck", int'(sck4), 0);
        check("mid_rst_ss", int'(ss4), 1);
        check("mid_rst_busy", int'(h4.busy), 0);
        check("mid_rst_dout", int'(h4.dout), 0);
        check("mid_rst_mosi", int'(mosi4), 0);
        rst = 1'b0;
        start_req(1'b0, 8'h5A, 1'b0);
        monitor(1'b0, 3000);
        check("post_rst_done", m_done, 65);
        check("post_rst_dout", m_dout, 8'h5A);
        check("post_rst_busy_low", m_busy, 73);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
